mips_shift_unit: RTL
====================

// Module: mips_shift_unit
// PURPOSE
//  Parametrised iterative shifter for the MIPS CPU execute stage. Handles
//  SLL/SRL/SRA and their variable forms, plus ROTR. Shifts up to STEP bits per
//  cycle, trading latency against area, and talks to the core through a
//  start/busy/done handshake. The CPU stalls its PC while busy is high.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; must be >= 2
//  STEP   1   max bits shifted per cycle; 1..WIDTH ($error at elaboration otherwise)
//  SHW    $clog2(WIDTH)  shift-amount width (localparam, not overridable)
// PORTS
//  clk      in   1      clock, all state updates on posedge
//  reset    in   1      synchronous, active-high
//  start    in   1      request; sampled only in IDLE or DONE
//  op       in   2      00 SLL, 01 SRL, 10 SRA, 11 ROTR (rotate right)
//  operand  in   WIDTH  value to shift (rt)
//  shamt    in   SHW    shift amount (instr[10:6] or rs[4:0] chosen by decoder)
//  busy     out  1      high while shifting (state SHIFT)
//  done     out  1      one-cycle pulse, result valid
//  result   out  WIDTH  last completed result, held until next done
// BEHAVIOUR
//  Reset (clk edge with reset=1, any state): state IDLE; busy=0, done=0,
//   result=0. Internal data, count and op registers are cleared. An operation
//   in flight is abandoned, and no done is produced for it.
//  Inputs are read only at the accepting edge; they may change afterwards.
//  FSM states: IDLE, SHIFT, DONE.
//   IDLE, start=1: latch operand, op and rem=shamt.
//    rem==0 -> DONE; else -> SHIFT.
//   IDLE, start=0: stay IDLE.
//   SHIFT, each edge: s=min(rem,STEP); data=shift(data,op,s); rem-=s.
//    If the new rem==0 -> DONE, writing the final data into result on the
//    same edge. Otherwise stay in SHIFT.
//   SHIFT: start is ignored (no queueing, no error).
//   DONE: done=1 for exactly this cycle.
//    start=1 is accepted exactly as in IDLE (back-to-back operation).
//    start=0 -> IDLE.
//  Latency, counted from the accepting edge E0 to the cycle with done=1:
//   1 cycle if shamt==0; otherwise ceil(shamt/STEP)+1 cycles.
//   Worst case is ceil((WIDTH-1)/STEP)+1.
//  busy=1 exactly in SHIFT. busy and done are never both high.
//  Shift rules per step s:
//   SLL: zero fill from LSB.
//   SRL: zero fill from MSB.
//   SRA: fill with the bit that was operand[WIDTH-1] when latched.
//   ROTR: bits leaving the LSB re-enter at the MSB.
//  All arithmetic is modulo WIDTH; the width of shamt caps the amount at
//  WIDTH-1. There is no overflow or exception output.
//  result changes only on entry to DONE or on reset. Intermediate values
//  never appear on result.
// TESTING
//  T1 WIDTH=32 STEP=1: start, op=SLL, operand=0x10, shamt=2
//     -> done in cycle 3, result=0x40; busy high for 2 cycles.
//  T2 Back-to-back: with done=1 from T1, start SLL 0x10 shamt=10
//     -> result=0x4000 with latency 11; no IDLE cycle in between.
//  T3 STEP=1: SRA 0x80000000 shamt=4 -> 0xF8000000.
//     SRL with the same inputs -> 0x08000000.
//     ROTR 0x000000F1 shamt=4 -> 0x1000000F.
//  T4 shamt=0, op=SRA, operand=0xDEADBEEF -> done after 1 cycle, busy never
//     high, result=0xDEADBEEF.
//  T5 STEP=8: SLL 0x1 shamt=31 -> latency 5, result=0x80000000.
//     Repeat the run with STEP=32 -> latency 2, same result.
//  T6 Robustness: pulse start at cycle 3 of a shamt=20 SLL operation
//     -> ignored, result is that of the original request.
//     Assert reset mid-shift -> busy=0, done=0, result=0 on the next cycle,
//     and no stray done afterwards.

Source files
------------

// File: rtl/mips_shift_unit_if.sv
// Start/busy/done handshake between the execute stage and the iterative shifter.
interface mips_shift_unit_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, operand, shamt,
    input  busy, done, result
  );

  modport slave (
    input  start, op, operand, shamt,
    output busy, done, result
  );
endinterface

// File: rtl/mips_shift_unit.sv
// Iterative SLL/SRL/SRA/ROTR unit for the MIPS execute stage. Moves up to
// STEP bit positions per clock. The core stalls its PC while busy is high.
module mips_shift_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input logic               clk,
  input logic               reset,
  mips_shift_unit_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);
  // One extra bit so that STEP == WIDTH is still representable.
  localparam logic [SHW:0] STEP_W = (SHW + 1)'(STEP);

  if (WIDTH < 2) begin : g_bad_width
    $error("mips_shift_unit: WIDTH must be >= 2");
  end
  if (STEP < 1 || STEP > WIDTH) begin : g_bad_step
    $error("mips_shift_unit: STEP must be in 1..WIDTH");
  end

  typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA, OP_ROTR} op_t;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state;
  op_t              op_q;
  logic [WIDTH-1:0] data;
  logic [SHW-1:0]   rem;
  logic [SHW-1:0]   step_amt;
  logic [WIDTH-1:0] shifted;

  // One step of the selected shift by s positions (s < WIDTH).
  // SRA keeps the MSB fixed, so the latched sign keeps filling every step.
  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                input op_t             o,
                                                input logic [SHW-1:0]  s);
    logic [WIDTH-1:0] r;
    case (o)
      OP_SLL:  r = d << s;
      OP_SRL:  r = d >> s;
      OP_SRA:  r = $signed(d) >>> s;
      default: r = (d >> s) | (d << (WIDTH - int'(s)));
    endcase
    return r;
  endfunction

  // Amount moved this cycle: min(rem, STEP), then the data after that move.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    step_amt = rem;
    if ({1'b0, rem} >= STEP_W) step_amt = STEP_W[SHW-1:0];
    shifted = shift_by(data, op_q, step_amt);
  end

  // Control FSM with registered busy/done/result.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: all state here is plain flops, so all of it is cleared; an
      // operation in flight is dropped without a done.
      state    <= S_IDLE;
      op_q     <= OP_SLL;
      data     <= '0;
      rem      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.result <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            data <= bus.operand;
            op_q <= op_t'(bus.op);
            rem  <= bus.shamt;
            if (bus.shamt == '0) begin
              state      <= S_DONE;
              bus.done   <= 1'b1;
              bus.result <= bus.operand;
            end else begin
              state    <= S_SHIFT;
              bus.busy <= 1'b1;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          // start is ignored while shifting.
          data <= shifted;
          rem  <= rem - step_amt;
          if (rem == step_amt) begin
            state      <= S_DONE;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            bus.result <= shifted;
          end
        end
        default: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
